// File: rtl/wb_uart_rx_master_pkg.sv
// Shared definitions for the Wishbone UART receive poller: FSM encoding,
// UART register offsets and byte-lane helpers.
package wb_uart_rx_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LSR_REQ = 3'd1,
    RBR_REQ = 3'd2,
    PUSH    = 3'd3,
    NEXT    = 3'd4
  } state_e;

  localparam logic [2:0] LSR_OFS    = 3'd5;
  localparam logic [2:0] RBR_OFS    = 3'd0;
  localparam int         LSR_DR_BIT = 0;
  localparam int         CH_SHIFT   = 20;

  function automatic logic [3:0] lane_sel(input logic [1:0] ofs);
    return 4'b0001 << ofs;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] dat, input logic [1:0] ofs);
    return dat[{ofs, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/wb_rd_port.sv
// Single Wishbone read handshake with registered bus outputs; the optional
// ack timeout is built when WB_UART_RX_MASTER_TIMEOUT_EN is defined.
module wb_rd_port
  import wb_uart_rx_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_next,
  input  logic [31:0] adr_next,
  input  logic [3:0]  sel_next,
  input  logic        ack,
  input  logic [31:0] dat,
  output logic        cyc,
  output logic [31:0] adr,
  output logic [3:0]  sel,
  output logic        done,
  output logic [7:0]  rd_byte,
  output logic        timeout
);

  // Handshake: cyc/stb rise on the edge that launches an access and fall on
  // the edge where ack (or timeout) is seen, so back-to-back reads always
  // leave one idle cycle and only one access is ever outstanding.
  logic launch;

  assign done    = cyc & ack;
  assign rd_byte = lane_byte(dat, adr[1:0]);
  assign launch  = req_next & ~done & ~timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 1'b0;
      adr <= BASE_ADDR;
      sel <= 4'b0000;
    end else begin
      cyc <= launch;
      adr <= adr_next;
      sel <= launch ? sel_next : 4'b0000;
    end
  end

`ifdef WB_UART_RX_MASTER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (!cyc || ack) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign timeout = cyc & ~ack & (wait_cnt == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/wb_uart_rx_master.sv
// Polls up to 16 UART channels over Wishbone and pushes received bytes into a
// downstream FIFO. Define WB_UART_RX_MASTER_TIMEOUT_EN to enable the ack timeout.
module wb_uart_rx_master
  import wb_uart_rx_master_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter int          CH_COUNT  = 16,
  parameter int          TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] ch_en_i,
  output logic [31:0] wb_adr_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        tf_full_i,
  output logic [7:0]  print_data_o,
  output logic        tf_push_o,
  output logic [3:0]  ch_o,
  output logic        err_o,
  input  logic        err_clr_i,
  output logic [2:0]  dbg_state
);

  localparam logic [3:0] CH_LAST = 4'(CH_COUNT - 1);

  state_e      state, next_state;
  logic [3:0]  ch, next_ch;
  logic [2:0]  req_ofs;
  logic        req_next;
  logic [31:0] adr_next;
  logic        push_now;
  logic        done;
  logic        timeout;
  logic [7:0]  rd_byte;
  logic [7:0]  data_q;
  logic [3:0]  ch_o_q;
  logic        push_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
      ch    <= 4'd0;
    end else begin
      state <= next_state;
      ch    <= next_ch;
    end
  end

  always_comb begin
    next_state = state;
    next_ch    = ch;
    unique case (state)
      IDLE: begin
        if (ch_en_i[ch] && (int'(ch) < CH_COUNT)) next_state = LSR_REQ;
        else                                      next_state = NEXT;
      end
      LSR_REQ: begin
        if (timeout)   next_state = NEXT;
        else if (done) next_state = rd_byte[LSR_DR_BIT] ? RBR_REQ : NEXT;
      end
      RBR_REQ: begin
        if (timeout)   next_state = NEXT;
        else if (done) next_state = PUSH;
      end
      PUSH: begin
        // A channel disabled during its transfer is left once the byte is pushed.
        if (!tf_full_i) next_state = ch_en_i[ch] ? LSR_REQ : NEXT;
      end
      NEXT: begin
        next_state = IDLE;
        next_ch    = (ch == CH_LAST) ? 4'd0 : ch + 4'd1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bus outputs are registered from next-state values, so the request is
  // already on the bus in the first cycle of LSR_REQ/RBR_REQ.
  always_comb begin
    req_ofs  = (next_state == RBR_REQ) ? RBR_OFS : LSR_OFS;
    req_next = (next_state == LSR_REQ) || (next_state == RBR_REQ);
    adr_next = BASE_ADDR | (32'(next_ch) << CH_SHIFT) | 32'(req_ofs);
    push_now = (state == PUSH) && !tf_full_i;
  end

  wb_rd_port #(
    .BASE_ADDR (BASE_ADDR),
    .TIMEOUT   (TIMEOUT)
  ) u_rd_port (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_i),
    .req_next (req_next),
    .adr_next (adr_next),
    .sel_next (lane_sel(req_ofs[1:0])),
    .ack      (wb_ack_i),
    .dat      (wb_dat_i),
    .cyc      (wb_cyc_o),
    .adr      (wb_adr_o),
    .sel      (wb_sel_o),
    .done     (done),
    .rd_byte  (rd_byte),
    .timeout  (timeout)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      data_q <= 8'd0;
      ch_o_q <= 4'd0;
      push_q <= 1'b0;
    end else begin
      if ((state == RBR_REQ) && done) data_q <= rd_byte;
      push_q <= push_now;
      if (push_now) ch_o_q <= ch;
    end
  end

`ifdef WB_UART_RX_MASTER_TIMEOUT_EN
  logic err_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i)      err_q <= 1'b0;
    else if (timeout)   err_q <= 1'b1;
    else if (err_clr_i) err_q <= 1'b0;
  end

  assign err_o = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_o          = 1'b0;
`endif

  assign wb_stb_o     = wb_cyc_o;
  assign wb_we_o      = 1'b0;
  assign print_data_o = data_q;
  assign ch_o         = ch_o_q;
  assign tf_push_o    = push_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_wb_uart_rx_master.sv
// Bench for wb_uart_rx_master: behavioural UART responders per channel and a
// push scoreboard; the timeout scenario is built with WB_UART_RX_MASTER_TIMEOUT_EN.
module tb_wb_uart_rx_master;
  import wb_uart_rx_master_pkg::*;

  localparam logic [31:0] BASE = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] ch_en = 16'h0000;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic        tf_full = 1'b0;
  logic [7:0]  print_data_o;
  logic        tf_push_o;
  logic [3:0]  ch_o;
  logic        err_o;
  logic        err_clr = 1'b0;
  logic [2:0]  dbg_state;

  int          vectors = 0;
  int          miscompares = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  uart_q[16][$];
  logic        resp_on = 1'b1;
  int          push_cnt = 0;
  logic        burst_on = 1'b0;
  int          burst_pushes = 0;
  int          foreign = 0;
  logic        cyc_d = 1'b0;

  wb_uart_rx_master #(
    .BASE_ADDR (BASE),
    .CH_COUNT  (16),
    .TIMEOUT   (4)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst_n),
    .ch_en_i      (ch_en),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_i     (wb_dat_i),
    .wb_sel_o     (wb_sel_o),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_ack_i     (wb_ack_i),
    .tf_full_i    (tf_full),
    .print_data_o (print_data_o),
    .tf_push_o    (tf_push_o),
    .ch_o         (ch_o),
    .err_o        (err_o),
    .err_clr_i    (err_clr),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // UART register model: LSR bit0 = data ready, RBR pops the channel FIFO
  function automatic logic [7:0] reg_val(input logic [3:0] c, input logic [2:0] ofs);
    if (ofs == LSR_OFS) return {7'b0, uart_q[c].size() != 0};
    if (uart_q[c].size() != 0) return uart_q[c][0];
    return 8'h00;
  endfunction

  function automatic logic [31:0] place(input logic [7:0] b, input logic [1:0] lane,
                                        input logic [31:0] fill);
    logic [31:0] d;
    d = fill;
    d[{lane, 3'b000} +: 8] = b;
    return d;
  endfunction

  // responder: ack one cycle after the request, random data on unused lanes
  initial forever begin
    @(posedge clk);
    if (wb_cyc_o && wb_stb_o && !wb_ack_i && resp_on) begin
      wb_ack_i <= 1'b1;
      wb_dat_i <= place(reg_val(wb_adr_o[23:20], wb_adr_o[2:0]), wb_adr_o[1:0], $urandom());
      if (wb_adr_o[2:0] == RBR_OFS && uart_q[wb_adr_o[23:20]].size() != 0)
        void'(uart_q[wb_adr_o[23:20]].pop_front());
    end else begin
      wb_ack_i <= 1'b0;
    end
  end

  // scoreboard and access monitor
  initial forever begin
    logic [11:0] e;
    @(negedge clk);
    if (tf_push_o) begin
      if (exp_q.size() == 0) begin
        check("push_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("push_data", {20'd0, ch_o, print_data_o}, {20'd0, e});
        push_cnt++;
        if (burst_on && ch_o == 4'd2) burst_pushes++;
      end
    end
    if (wb_cyc_o && !cyc_d) begin
      check("stb_eq_cyc", {31'd0, wb_stb_o}, 32'd1);
      check("we_low", {31'd0, wb_we_o}, 32'd0);
      if (burst_on && burst_pushes > 0 && burst_pushes < 3 && wb_adr_o[23:20] != 4'd2)
        foreign++;
    end
    cyc_d = wb_cyc_o;
  end

  task automatic load(input int c, input logic [7:0] b);
    uart_q[c].push_back(b);
    exp_q.push_back({4'(c), b});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n, c, nb, base_push;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, nb, base_push;
    // reset state
    #12;
    check("rst_state", {29'd0, dbg_state}, 32'(IDLE));
    check("rst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("rst_adr", wb_adr_o, BASE);
    check("rst_sel", {28'd0, wb_sel_o}, 32'd0);
    check("rst_push", {31'd0, tf_push_o}, 32'd0);
    check("rst_data", {24'd0, print_data_o}, 32'd0);
    check("rst_ch_o", {28'd0, ch_o}, 32'd0);
    check("rst_err", {31'd0, err_o}, 32'd0);

    // single byte on ch0, then the scan moves to ch1
    ch_en = 16'h0001;
    load(0, 8'h41);
    tick();
    rst_n = 1'b1;
    tick();
    check("first_cyc", {31'd0, wb_cyc_o}, 32'd1);
    check("first_adr", wb_adr_o, 32'h6000_0005);
    check("first_sel", {28'd0, wb_sel_o}, 32'h2);
    n = 0;
    while (wb_adr_o != 32'h6010_0005 && n < 200) begin
      tick();
      n++;
    end
    check("adr_ch1", wb_adr_o, 32'h6010_0005);
    check("one_push", push_cnt, 1);
    wait_drain(200);

    // drain burst of three bytes on ch2
    ch_en = 16'h0005;
    burst_on = 1'b1;
    load(2, 8'h10);
    load(2, 8'h11);
    load(2, 8'h12);
    wait_drain(500);
    check("burst_pushes", burst_pushes, 3);
    check("burst_foreign", foreign, 0);
    burst_on = 1'b0;

    // downstream full holds the push and the bus
    tf_full = 1'b1;
    ch_en = 16'h0001;
    load(0, 8'h5A);
    n = 0;
    while (dbg_state != 3'(PUSH) && n < 300) begin
      tick();
      n++;
    end
    check("reach_push", {29'd0, dbg_state}, 32'(PUSH));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("full_push_low", {31'd0, tf_push_o}, 32'd0);
      check("full_cyc_low", {31'd0, wb_cyc_o}, 32'd0);
    end
    tf_full = 1'b0;
    tick();
    check("push_after_full", {31'd0, tf_push_o}, 32'd1);
    wait_drain(100);

    // random channels, enables and byte counts
    for (int it = 0; it < 6; it++) begin
      c = $urandom_range(0, 15);
      ch_en = 16'($urandom_range(0, 16'hFFFF)) | (16'd1 << c);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) load(c, 8'($urandom_range(0, 255)));
      wait_drain(2000);
    end

`ifdef WB_UART_RX_MASTER_TIMEOUT_EN
    // silent responder: access times out, err is sticky, scan continues
    resp_on = 1'b0;
    ch_en = 16'h0003;
    base_push = push_cnt;
    n = 0;
    while (!(wb_cyc_o && wb_adr_o[23:20] == 4'd0) && n < 200) begin
      tick();
      n++;
    end
    n = 0;
    while (wb_cyc_o && n < 50) begin
      tick();
      n++;
    end
    check("to_cyc_cycles", n, 4);
    check("err_set", {31'd0, err_o}, 32'd1);
    n = 0;
    while (!wb_cyc_o && n < 50) begin
      tick();
      n++;
    end
    check("scan_continues", {28'd0, wb_adr_o[23:20]}, 32'd1);
    while (wb_cyc_o && n < 100) begin
      tick();
      n++;
    end
    check("err_sticky", {31'd0, err_o}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", {31'd0, err_o}, 32'd0);
    check("to_no_push", push_cnt, base_push);
    ch_en = 16'h0000;
    repeat (20) tick();
    resp_on = 1'b1;
`else
    check("err_tied_low", {31'd0, err_o}, 32'd0);
`endif

    // reset while the RBR read is on the bus
    ch_en = 16'h0001;
    load(0, 8'hC3);
    n = 0;
    while (!(dbg_state == 3'(RBR_REQ) && wb_cyc_o) && n < 300) begin
      tick();
      n++;
    end
    check("reach_rbr", {29'd0, dbg_state}, 32'(RBR_REQ));
    #2 rst_n = 1'b0;
    #1;
    check("arst_cyc", {31'd0, wb_cyc_o}, 32'd0);
    check("arst_stb", {31'd0, wb_stb_o}, 32'd0);
    check("arst_push", {31'd0, tf_push_o}, 32'd0);
    check("arst_adr", wb_adr_o, BASE);
    tick();
    tick();
    check("rst_hold_push", {31'd0, tf_push_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("restart_adr", wb_adr_o, 32'h6000_0005);
    wait_drain(300);

    repeat (10) tick();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
